// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order fetches to a variable-latency
// instruction memory, buffers returned words and presents decoder fields.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   imem_req_valid/ready/addr fetch request handshake and word address
//   imem_rsp_valid/data       in-order response, always accepted
//   redirect/redirect_target  taken branch / PC write from execute
//   stall                     downstream not consuming this cycle
//   if_valid, if_instr, if_pc, if_pc_plus8, if_cond, if_op, if_cmd, if_ind
//                             buffer head and its decoded slices
module fetch_stage #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              stall,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus8,
    output logic [3:0]        if_cond,
    output logic [1:0]        if_op,
    output logic [3:0]        if_cmd,
    output logic [1:0]        if_ind
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST  = PW'(BUF_DEPTH - 1);
    localparam logic [CW:0]   DEPTH = (CW+1)'(BUF_DEPTH);

    logic [ADDR_W-1:0] pc;
    logic              epoch;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     bcount;

    // request-order FIFO: epoch and PC of every in-flight fetch
    logic              tag_ep [BUF_DEPTH];
    logic [ADDR_W-1:0] tag_pc [BUF_DEPTH];
    logic [PW-1:0]     tag_wp;
    logic [PW-1:0]     tag_rp;

    // instruction buffer
    logic [31:0]       buf_ins [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc  [BUF_DEPTH];
    logic [PW-1:0]     buf_wp;
    logic [PW-1:0]     buf_rp;

    logic [CW:0] used;
    logic        issue;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // credits come from registered counts only, so a slot freed by a
    // pop this cycle is not reusable until the next cycle
    assign used           = {1'b0, outstanding} + {1'b0, bcount};
    assign imem_req_valid = rst && !redirect && (used < DEPTH);
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // stale-epoch responses and any response racing a redirect are dropped
    assign push = imem_rsp_valid && !redirect &&
                  (tag_ep[tag_rp] == epoch);

    assign if_valid = (bcount != '0);
    assign pop      = if_valid && !stall && !redirect;

    assign if_instr    = if_valid ? buf_ins[buf_rp] : '0;
    assign if_pc       = if_valid ? buf_pc[buf_rp] : '0;
    assign if_pc_plus8 = if_valid ? buf_pc[buf_rp] + ADDR_W'(8) : '0;
    assign if_cond     = if_instr[31:28];
    assign if_op       = if_instr[27:26];
    assign if_cmd      = if_instr[24:21];
    assign if_ind      = {if_instr[25], if_instr[20]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            epoch       <= 1'b0;
            outstanding <= '0;
            tag_wp      <= '0;
            tag_rp      <= '0;
            bcount      <= '0;
            buf_wp      <= '0;
            buf_rp      <= '0;
        end else begin
            if (redirect) begin
                pc    <= redirect_target;
                epoch <= ~epoch;
            end else if (issue) begin
                pc <= pc + ADDR_W'(4);
            end

            if (issue) begin
                tag_wp <= inc(tag_wp);
            end
            if (imem_rsp_valid) begin
                tag_rp <= inc(tag_rp);
            end
            if (issue && !imem_rsp_valid) begin
                outstanding <= outstanding + CW'(1);
            end else if (!issue && imem_rsp_valid) begin
                outstanding <= outstanding - CW'(1);
            end

            if (redirect) begin
                bcount <= '0;
                buf_wp <= '0;
                buf_rp <= '0;
            end else begin
                if (push) begin
                    buf_wp <= inc(buf_wp);
                end
                if (pop) begin
                    buf_rp <= inc(buf_rp);
                end
                if (push && !pop) begin
                    bcount <= bcount + CW'(1);
                end else if (pop && !push) begin
                    bcount <= bcount - CW'(1);
                end
            end
        end
    end

    // storage needs no reset: pointers and counts qualify every read
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_ep[tag_wp] <= epoch;
            tag_pc[tag_wp] <= pc;
        end
        if (push) begin
            buf_ins[buf_wp] <= imem_rsp_data;
            buf_pc[buf_wp]  <= tag_pc[tag_rp];
        end
    end

    a_rsp_orphan: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps plus randomized traffic for fetch_stage,
// checked against a program-order model of requests and deliveries.
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus8;
    logic [3:0]  if_cond;
    logic [1:0]  if_op;
    logic [3:0]  if_cmd;
    logic [1:0]  if_ind;

    fetch_stage #(
        .ADDR_W(32),
        .RESET_PC(32'h0),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .stall(stall),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .if_pc_plus8(if_pc_plus8),
        .if_cond(if_cond),
        .if_op(if_op),
        .if_cmd(if_cmd),
        .if_ind(if_ind)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'hE0810002;
        if (a == 32'h4) return 32'hE2411001;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // memory model
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t memq[$];
    mreq_t mq;
    int    cyc_n = 0;
    int    lat = 1;
    bit    lat_rand = 0;
    bit    rdy_rand = 0;

    always @(posedge clk) begin
        #1;
        cyc_n++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!rst) begin
            memq.delete();
        end else if (memq.size() > 0 && memq[0].due <= cyc_n) begin
            mq = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mq.addr);
        end
    end

    // reference model: requests and deliveries follow program order from
    // the last redirect; a response is live only if no redirect happened
    // since its request
    int          sbq[$];
    int          gen = 0;
    int          inflight = 0;
    int          buffered = 0;
    int          n_del = 0;
    int          n_acc = 0;
    logic [31:0] exp_issue = 32'h0;
    logic [31:0] exp_out = 32'h0;
    logic [31:0] w;
    bit          ev;
    bit          live;
    int          g;

    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            inflight  = 0;
            buffered  = 0;
            exp_issue = 32'h0;
            exp_out   = 32'h0;
        end else begin
            ev = !redirect && (inflight + buffered < DEPTH);
            chk("req_valid", 32'(imem_req_valid), 32'(ev));
            if (ev) chk("req_addr", imem_req_addr, exp_issue);
            chk("if_valid", 32'(if_valid), 32'(buffered > 0));
            if (buffered > 0) begin
                w = memfn(exp_out);
                chk("if_pc", if_pc, exp_out);
                chk("if_instr", if_instr, w);
                chk("if_fields", 32'({if_cond, if_op, if_cmd, if_ind}),
                    32'({w[31:28], w[27:26], w[24:21], w[25], w[20]}));
                chk("if_pc8", if_pc_plus8, exp_out + 32'd8);
            end
            live = 1'b0;
            if (imem_rsp_valid && sbq.size() > 0) begin
                g = sbq.pop_front();
                live = (g == gen) && !redirect;
                inflight--;
            end
            if (redirect) begin
                gen++;
                exp_issue = redirect_target;
                exp_out   = redirect_target;
                buffered  = 0;
            end else begin
                if (buffered > 0 && !stall) begin
                    exp_out += 32'd4;
                    buffered--;
                    n_del++;
                end
                if (live) buffered++;
                if (ev && imem_req_ready) begin
                    sbq.push_back(gen);
                    exp_issue += 32'd4;
                    inflight++;
                    n_acc++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.addr = imem_req_addr;
                mq.due  = cyc_n + (lat_rand ? $urandom_range(1, 4) : lat);
                memq.push_back(mq);
            end
        end
    end

    task automatic wait_deliv(input string tag, input logic [31:0] exp);
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (if_valid && !stall && !redirect) begin
                got = 1;
                chk(tag, if_pc, exp);
                chk({tag, "_pc8"}, if_pc_plus8, exp + 32'd8);
            end
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    int acc_base;
    int d0;
    bit got;

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc8", if_pc_plus8, 32'h0);

        // stream with 1-cycle memory
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("second_req_valid", 32'(imem_req_valid), 32'd1);
        chk("second_req_addr", imem_req_addr, 32'h4);
        chk("early_if_valid", 32'(if_valid), 32'd0);

        // backpressure from the first valid instruction
        @(posedge clk); #1;
        stall = 1'b1;
        acc_base = n_acc;
        @(negedge clk);
        chk("head_valid", 32'(if_valid), 32'd1);
        chk("head_pc", if_pc, 32'h0);
        chk("head_cond", 32'(if_cond), 32'hE);
        chk("head_op", 32'(if_op), 32'h0);
        chk("head_cmd", 32'(if_cmd), 32'h4);
        chk("head_ind", 32'(if_ind), 32'h0);
        chk("head_pc8", if_pc_plus8, 32'h8);
        repeat (5) @(negedge clk);
        chk("bp_req_off", 32'(imem_req_valid), 32'd0);
        chk("bp_head_hold", if_pc, 32'h0);
        @(posedge clk); #1;
        stall = 1'b0;
        chk("bp_extra", 32'(n_acc - acc_base <= 2), 32'd1);
        wait_deliv("bp_d0", 32'h0);
        wait_deliv("bp_d1", 32'h4);
        wait_deliv("bp_d2", 32'h8);
        wait_deliv("bp_d3", 32'hC);

        // redirect with two fetches in flight
        lat = 3;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (inflight == 2) got = 1;
        end
        chk("rd_inflight2", 32'(got), 32'd1);
        redirect = 1'b1;
        redirect_target = 32'h100;
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_deliv("rd_first", 32'h100);
        wait_deliv("rd_second", 32'h104);

        // redirect while stalled with a full buffer
        lat = 1;
        @(posedge clk); #1;
        stall = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_target = 32'h180;
        @(negedge clk);
        chk("full_ifv", 32'(if_valid), 32'd1);
        chk("full_rd_req", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        redirect = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("flush_ifv", 32'(if_valid), 32'd0);
        wait_deliv("flush_tgt", 32'h180);

        // back-to-back redirects
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'h200;
        @(posedge clk); #1;
        redirect_target = 32'h300;
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_deliv("b2b_last", 32'h300);

        // address wrap
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_deliv("wrap0", 32'hFFFF_FFF8);
        wait_deliv("wrap1", 32'hFFFF_FFFC);
        wait_deliv("wrap2", 32'h0);

        // randomized traffic
        lat_rand = 1;
        rdy_rand = 1;
        @(posedge clk); #1;
        d0 = n_del;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            stall = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 24) == 0);
            redirect_target = $urandom & 32'hFFFF_FFFC;
        end
        @(posedge clk); #1;
        redirect = 1'b0;
        stall = 1'b0;
        chk("rand_progress", 32'(n_del - d0 >= 50), 32'd1);

        // asynchronous reset mid-operation
        lat_rand = 0;
        rdy_rand = 0;
        lat = 3;
        stall = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mr_if_valid", 32'(if_valid), 32'd0);
        chk("mr_req_addr", imem_req_addr, 32'h0);
        chk("mr_if_pc", if_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        stall = 1'b0;
        wait_deliv("mr_first", 32'h0);
        wait_deliv("mr_second", 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
